// File: rtl/bcau_pkg.sv
// Shared types and elaboration helpers for the BCAU control slice.
package bcau_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DRAIN = 3'd2,
    AVG   = 3'd3,
    CALC  = 3'd4,
    DONE  = 3'd5
  } bcau_state_t;

  function automatic int beats(input int win_pixels, input int lanes);
    return win_pixels / lanes;
  endfunction

  // Register width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcau_beat_counter.sv
// Beat / row / block position counters for one pass over the window.
module bcau_beat_counter
  import bcau_pkg::*;
#(
  parameter int BEATS    = 80,
  parameter int BLK_ROWS = 4,
  parameter int NUM_BLK  = 5,
  parameter int BW       = cnt_w(NUM_BLK)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_clr,
  input  logic          i_inc,
  output logic          o_last,
  output logic [BW-1:0] o_block
);

  localparam int BEAT_W = cnt_w(BEATS);
  localparam int ROW_W  = cnt_w(BLK_ROWS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(BLK_ROWS - 1);
  localparam logic [BW-1:0]     LAST_BLK  = BW'(NUM_BLK - 1);

  logic [BEAT_W-1:0] r_beat;
  logic [ROW_W-1:0]  r_row;
  logic [BW-1:0]     r_block;
  logic              w_row_last;

  assign w_row_last = (r_row == LAST_ROW);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat  <= '0;
      r_row   <= '0;
      r_block <= '0;
    end else if (i_clr) begin
      r_beat  <= '0;
      r_row   <= '0;
      r_block <= '0;
    end else if (i_inc) begin
      r_beat <= o_last ? '0 : r_beat + BEAT_W'(1);
      if (w_row_last) begin
        r_row   <= '0;
        r_block <= (r_block == LAST_BLK) ? '0 : r_block + BW'(1);
      end else begin
        r_row <= r_row + ROW_W'(1);
      end
    end
  end

  assign o_last  = (r_beat == LAST_BEAT);
  assign o_block = r_block;

endmodule

// File: rtl/bcau_ctrl_param.sv
// BCAU control unit: sequences load, accumulate, drain, average and output passes
// over one pixel window, with bypass, hold, flush and back-to-back acceptance.
module bcau_ctrl_param
  import bcau_pkg::*;
#(
  parameter int WIN_PIXELS = 400,
  parameter int LANES      = 5,
  parameter int BLK_ROWS   = 4,
  parameter int NUM_BLK    = 5,
  parameter int ACC_LAT    = 2,
  localparam int BW        = cnt_w(NUM_BLK)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_bypass,
  input  logic          out_ready,
  input  logic          hold,
  input  logic          flush,
  output logic          in_ready,
  output logic          out_valid,
  output logic          wr_in_all,
  output logic          cir_fifo,
  output logic          wr_accum,
  output logic          set_avg,
  output logic          shft_out,
  output logic          clr_accum,
  output logic [BW-1:0] block_sel,
  output logic          busy
);

  localparam int BEATS = beats(WIN_PIXELS, LANES);
  localparam int DRN_W = cnt_w(ACC_LAT);
  localparam logic [DRN_W-1:0] LAST_DRN = DRN_W'((ACC_LAT > 0) ? ACC_LAT - 1 : 0);

  if (WIN_PIXELS % LANES != 0) begin : g_bad_geometry
    $error("bcau_ctrl_param: WIN_PIXELS must be a multiple of LANES");
  end
  if (NUM_BLK < 1) begin : g_bad_num_blk
    $error("bcau_ctrl_param: NUM_BLK must be at least 1");
  end
  if (BLK_ROWS < 1) begin : g_bad_blk_rows
    $error("bcau_ctrl_param: BLK_ROWS must be at least 1");
  end

  bcau_state_t      r_state;
  bcau_state_t      w_next;
  logic             r_bypass;
  logic [DRN_W-1:0] r_drain;
  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_last;

  bcau_beat_counter #(
    .BEATS    (BEATS),
    .BLK_ROWS (BLK_ROWS),
    .NUM_BLK  (NUM_BLK),
    .BW       (BW)
  ) u_beat_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_cnt_clr),
    .i_inc   (w_cnt_inc),
    .o_last  (w_last),
    .o_block (block_sel)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_inc = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    wr_in_all = 1'b0;
    cir_fifo  = 1'b0;
    wr_accum  = 1'b0;
    set_avg   = 1'b0;
    shft_out  = 1'b0;
    clr_accum = 1'b0;

    if (flush) begin
      clr_accum = 1'b1;
      w_cnt_clr = 1'b1;
      w_next    = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          in_ready = 1'b1;
          w_accept = in_valid;
        end
        ACCUM: if (!hold) begin
          // A bypassed window never reaches here; the guard keeps accumulator strobes off regardless.
          wr_accum  = !r_bypass;
          cir_fifo  = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_last) w_next = (ACC_LAT == 0) ? AVG : DRAIN;
        end
        DRAIN: if (r_drain == LAST_DRN) w_next = AVG;
        AVG: begin
          set_avg   = !r_bypass;
          w_cnt_clr = 1'b1;
          w_next    = CALC;
        end
        CALC: if (!hold) begin
          shft_out  = 1'b1;
          cir_fifo  = 1'b1;
          w_cnt_inc = 1'b1;
          if (w_last) w_next = DONE;
        end
        DONE: begin
          out_valid = 1'b1;
          in_ready  = out_ready;
          if (out_ready) begin
            clr_accum = 1'b1;
            w_next    = IDLE;
            w_accept  = in_valid;
          end
        end
        default: w_next = IDLE;
      endcase

      if (w_accept) begin
        wr_in_all = 1'b1;
        w_cnt_clr = 1'b1;
        w_next    = in_bypass ? CALC : ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bypass <= 1'b0;
      r_drain  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_bypass <= in_bypass;
      r_drain <= (r_state == DRAIN) ? r_drain + DRN_W'(1) : '0;
    end
  end

  assign busy = (r_state != IDLE);

endmodule
